// File: rtl/vector_mem_reader_pkg.sv
// Shared types and defaults for the dot-product vector reader/writer.
package vector_mem_reader_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_VECTOR_WIDTH = 4;
    localparam int DEF_ADDR_WIDTH   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } rd_state_t;

    // Element index must also reach VECTOR_WIDTH (the drain cycle).
    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vector_mem_reader_if.sv
// Memory read bus plus vector handshake of the vector reader.
interface vector_mem_reader_if
    import vector_mem_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
);
    logic                               start;
    logic [ADDR_WIDTH:0]                num_vectors;
    logic                               rd_en;
    logic [ADDR_WIDTH-1:0]              rd_addr;
    logic [DATA_WIDTH-1:0]              rd_data_a;
    logic [DATA_WIDTH-1:0]              rd_data_b;
    logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vec_a;
    logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vec_b;
    logic                               vec_valid;
    logic                               vec_ready;
    logic                               reader_busy;
    logic                               reader_done;
    logic [ADDR_WIDTH:0]                vector_count;

    modport master (
        input  start, num_vectors, rd_data_a, rd_data_b, vec_ready,
        output rd_en, rd_addr, vec_a, vec_b, vec_valid,
        output reader_busy, reader_done, vector_count
    );

    modport slave (
        output start, num_vectors, rd_data_a, rd_data_b, vec_ready,
        input  rd_en, rd_addr, vec_a, vec_b, vec_valid,
        input  reader_busy, reader_done, vector_count
    );
endinterface

// File: rtl/vector_mem_reader_packer.sv
// Element insert register building vec_a/vec_b from returning read data.
module vector_packer
    import vector_mem_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
    parameter int IW           = idx_width(DEF_VECTOR_WIDTH)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_we,
    input  logic [IW-1:0]                      i_idx,
    input  logic [DATA_WIDTH-1:0]              i_data_a,
    input  logic [DATA_WIDTH-1:0]              i_data_b,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0] o_vec_a,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0] o_vec_b
);
    logic [DATA_WIDTH-1:0] r_a [VECTOR_WIDTH];
    logic [DATA_WIDTH-1:0] r_b [VECTOR_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < VECTOR_WIDTH; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else begin
            for (int k = 0; k < VECTOR_WIDTH; k++) begin
                if (i_we && i_idx == IW'(k)) begin
                    r_a[k] <= i_data_a;
                    r_b[k] <= i_data_b;
                end
            end
        end
    end

    for (genvar g = 0; g < VECTOR_WIDTH; g++) begin : g_pack
        assign o_vec_a[g*DATA_WIDTH +: DATA_WIDTH] = r_a[g];
        assign o_vec_b[g*DATA_WIDTH +: DATA_WIDTH] = r_b[g];
    end
endmodule

// File: rtl/vector_mem_reader.sv
// Reads num_vectors vector pairs from two memories; stall counter
// available when READER_STALL_CNT_EN is defined.
module vector_mem_reader
    import vector_mem_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    vector_mem_reader_if.master bus
`ifdef READER_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cycles
`endif
);
    localparam int IW = idx_width(VECTOR_WIDTH);
    localparam logic [IW-1:0] J_ONE  = IW'(1);
    localparam logic [IW-1:0] J_LAST = IW'(VECTOR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0] C_ONE = (ADDR_WIDTH+1)'(1);

    rd_state_t             r_state;
    rd_state_t             w_next;
    logic [ADDR_WIDTH:0]   r_num;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_inc;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [IW-1:0]         r_j;
    logic                  r_cap_we;
    logic [IW-1:0]         r_cap_idx;
    logic                  w_start;
    logic                  w_rd_en;
    logic                  w_xfer;

    assign w_start     = (r_state == S_IDLE) && bus.start;
    assign w_rd_en     = (r_state == S_FETCH) && (r_j < J_LAST);
    assign w_xfer      = (r_state == S_PRESENT) && bus.vec_ready;
    assign w_count_inc = r_count + C_ONE;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start)
                    w_next = (bus.num_vectors == '0) ? S_DONE : S_FETCH;
            end
            // One extra FETCH cycle drains the last read's return data.
            S_FETCH: begin
                if (r_j == J_LAST)
                    w_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (bus.vec_ready)
                    w_next = (w_count_inc < r_num) ? S_FETCH : S_DONE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_num     <= '0;
            r_count   <= '0;
            r_addr    <= '0;
            r_j       <= '0;
            r_cap_we  <= 1'b0;
            r_cap_idx <= '0;
        end else begin
            r_state   <= w_next;
            r_cap_we  <= w_rd_en;
            r_cap_idx <= r_j;
            r_j       <= (r_state == S_FETCH) ? r_j + J_ONE : '0;
            if (w_start) begin
                r_num   <= bus.num_vectors;
                r_count <= '0;
                r_addr  <= '0;
            end else begin
                if (w_xfer)
                    r_count <= w_count_inc;
                if (w_rd_en)
                    r_addr <= r_addr + A_ONE;
            end
        end
    end

    vector_packer #(
        .DATA_WIDTH   (DATA_WIDTH),
        .VECTOR_WIDTH (VECTOR_WIDTH),
        .IW           (IW)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (r_cap_we),
        .i_idx    (r_cap_idx),
        .i_data_a (bus.rd_data_a),
        .i_data_b (bus.rd_data_b),
        .o_vec_a  (bus.vec_a),
        .o_vec_b  (bus.vec_b)
    );

    assign bus.rd_en        = w_rd_en;
    assign bus.rd_addr      = r_addr;
    assign bus.vec_valid    = (r_state == S_PRESENT);
    assign bus.reader_busy  = (r_state == S_FETCH) || (r_state == S_PRESENT);
    assign bus.reader_done  = (r_state == S_DONE);
    assign bus.vector_count = r_count;

`ifdef READER_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall <= '0;
        else if (w_start)
            r_stall <= '0;
        else if (r_state == S_PRESENT && !bus.vec_ready && r_stall != 16'hFFFF)
            r_stall <= r_stall + 16'd1;
    end

    assign stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_vector_mem_reader.sv
// Self-checking bench for vector_mem_reader against a memory/vector model.
module tb_vector_mem_reader;
    localparam int DW    = 8;
    localparam int VW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        string name;
        int    num;
        int    stall_vec;
        int    stall_len;
        bit    glitch;
        bit    rnd;
        int    exp_xfers;
        int    exp_stall;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];
    int total;
    int bad;
`ifdef READER_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    vector_mem_reader_if #(.DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .ADDR_WIDTH(AW)) bus ();

    vector_mem_reader #(
        .DATA_WIDTH   (DW),
        .VECTOR_WIDTH (VW),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
`ifdef READER_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data one cycle after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= mem1[bus.rd_addr];
            bus.rd_data_b <= mem2[bus.rd_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [VW*DW-1:0] model_vec(input bit side_b, input int k);
        logic [VW*DW-1:0] v;
        v = '0;
        for (int j = 0; j < VW; j++)
            v[j*DW +: DW] = side_b ? mem2[(k*VW + j) % DEPTH]
                                   : mem1[(k*VW + j) % DEPTH];
        return v;
    endfunction

    task automatic run(input vec_t v);
        int addrs[$];
        int xfers, dones, stalls, busy_seen, rd_bad, unstable, wrong;
        int cyc, post, st_left, mism;
        bit held;
        logic [VW*DW-1:0] ha, hb;
        xfers = 0; dones = 0; stalls = 0; busy_seen = 0; rd_bad = 0;
        unstable = 0; wrong = 0; cyc = 0; post = 0; held = 0;
        st_left = v.stall_len; ha = '0; hb = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_vectors = (AW+1)'(v.num);
        @(negedge clk);
        while (cyc < 3000) begin
            if (bus.rd_en) addrs.push_back(int'(bus.rd_addr));
            if (bus.reader_busy) busy_seen++;
            if (bus.reader_done) begin
                dones++;
                if (post == 0) post = 1;
            end
            bus.start = v.glitch && cyc == 2;
            bus.num_vectors = (v.glitch && cyc == 2) ? (AW+1)'(7) : (AW+1)'(v.num);
            if (bus.vec_valid) begin
                if (bus.rd_en) rd_bad++;
                if (held && (bus.vec_a !== ha || bus.vec_b !== hb)) unstable++;
                if (!held && (bus.vec_a !== model_vec(0, xfers) ||
                              bus.vec_b !== model_vec(1, xfers))) wrong++;
                held = 1; ha = bus.vec_a; hb = bus.vec_b;
                if (xfers == v.stall_vec && st_left > 0) begin
                    bus.vec_ready = 1'b0;
                    st_left--;
                end else if (v.rnd) begin
                    bus.vec_ready = 1'($urandom_range(0, 1));
                end else begin
                    bus.vec_ready = 1'b1;
                end
                if (bus.vec_ready) begin
                    xfers++;
                    held = 0;
                end else begin
                    stalls++;
                end
            end else begin
                bus.vec_ready = 1'($urandom_range(0, 1));
            end
            if (post > 0) post++;
            if (post > 3) break;
            @(negedge clk);
            cyc++;
        end
        mism = 0;
        for (int k = 0; k < v.num; k++)
            for (int j = 0; j < VW; j++)
                if (k*VW + j < addrs.size() && addrs[k*VW + j] != (k*VW + j) % DEPTH)
                    mism++;
        check({v.name, ":addr_cnt"}, addrs.size(), v.num * VW);
        check({v.name, ":addr_seq"}, mism, 0);
        check({v.name, ":xfers"}, xfers, v.exp_xfers);
        check({v.name, ":done_pulses"}, dones, 1);
        check({v.name, ":data"}, wrong, 0);
        check({v.name, ":stable"}, unstable, 0);
        check({v.name, ":rd_in_present"}, rd_bad, 0);
        check({v.name, ":busy_seen"}, busy_seen != 0, v.num != 0);
        check({v.name, ":vector_count"}, bus.vector_count, v.num);
`ifdef READER_STALL_CNT_EN
        check({v.name, ":stall_cycles"}, stall_cycles,
              v.exp_stall < 0 ? stalls : v.exp_stall);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":rd_en"}, bus.rd_en, 0);
        check({tag, ":rd_addr"}, bus.rd_addr, 0);
        check({tag, ":vec_a"}, bus.vec_a, 0);
        check({tag, ":vec_b"}, bus.vec_b, 0);
        check({tag, ":vec_valid"}, bus.vec_valid, 0);
        check({tag, ":busy"}, bus.reader_busy, 0);
        check({tag, ":done"}, bus.reader_done, 0);
        check({tag, ":count"}, bus.vector_count, 0);
    endtask

    initial begin
        vec_t tbl[7];
        vec_t rv;
        int waited;
        total = 0;
        bad = 0;
        tbl[0] = '{"stall3",   3, 1, 10, 0, 0, 3, 10};
        tbl[1] = '{"zero",     0, -1, 0, 0, 0, 0, 0};
        tbl[2] = '{"glitch",   2, -1, 0, 1, 0, 2, 0};
        tbl[3] = '{"wrap5",    5, -1, 0, 0, 0, 5, 0};
        tbl[4] = '{"stall1",   1, 0, 3, 0, 0, 1, 3};
        tbl[5] = '{"rand6",    6, -1, 0, 0, 1, 6, -1};
        tbl[6] = '{"rand4",    4, 2, 4, 0, 1, 4, -1};

        for (int i = 0; i < DEPTH; i++) begin
            mem1[i] = DW'(i + 1);
            mem2[i] = DW'(i + 5);
        end
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.num_vectors = '0;
        bus.vec_ready = 1'b1;
        bus.rd_data_a = '0;
        bus.rd_data_b = '0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single vector, exact latency.
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_vectors = 1;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k <= 4) begin
                check($sformatf("lat:rd_en%0d", k), bus.rd_en, k < 4);
                if (k < 4) check($sformatf("lat:addr%0d", k), bus.rd_addr, k);
            end
            if (k <= 5) check($sformatf("lat:valid%0d", k), bus.vec_valid, k == 5);
            if (k == 5) begin
                check("lat:vec_a", bus.vec_a, 32'h04030201);
                check("lat:vec_b", bus.vec_b, 32'h08070605);
                check("lat:busy", bus.reader_busy, 1);
            end
            if (k == 6) begin
                check("lat:done", bus.reader_done, 1);
                check("lat:count", bus.vector_count, 1);
                check("lat:busy_done", bus.reader_busy, 0);
            end
            if (k == 7) check("lat:done_once", bus.reader_done, 0);
        end

        for (int i = 0; i < 7; i++) run(tbl[i]);

        // Reset during the second FETCH of a 4-vector run.
        @(negedge clk);
        bus.vec_ready = 1'b1;
        bus.start = 1'b1;
        bus.num_vectors = 4;
        @(negedge clk);
        bus.start = 1'b0;
        waited = 0;
        while (!(bus.vector_count == 1 && bus.rd_en) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("midrst:reached", waited < 100, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        rv = '{"after_rst", 4, -1, 0, 0, 0, 4, 0};
        run(rv);

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem1[i] = DW'($urandom);
                mem2[i] = DW'($urandom);
            end
            rv.name = $sformatf("rnd%0d", r);
            rv.num = $urandom_range(0, 8);
            rv.stall_vec = -1;
            rv.stall_len = 0;
            rv.glitch = 1'($urandom_range(0, 1)) && rv.num > 1;
            rv.rnd = 1'b1;
            rv.exp_xfers = rv.num;
            rv.exp_stall = -1;
            run(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vector_mem_reader.md
VECTOR_MEM_READER -- requirements
Module: vector_mem_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter VECTOR_WIDTH, default 4, elements per vector.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, memory address width; depth = 2**ADDR_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a read run.
REQ-007 SHALL have port num_vectors  input  ADDR_WIDTH+1  vectors to read, sampled with start.
REQ-008 SHALL have port rd_en  output  1  read strobe to both source memories (mem1, mem2).
REQ-009 SHALL have port rd_addr  output  ADDR_WIDTH  shared read address.
REQ-010 SHALL have port rd_data_a / rd_data_b  input  DATA_WIDTH each  memory data, valid one cycle after rd_en.
REQ-011 SHALL have port vec_a / vec_b  output  VECTOR_WIDTH*DATA_WIDTH each  packed vectors, element j at bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port vec_valid  input-side handshake output  1; vec_ready  input  1  consumer accept.
REQ-013 SHALL have ports reader_busy  output  1, reader_done  output  1, vector_count  output  ADDR_WIDTH+1.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, PRESENT, DONE.
REQ-015 IDLE: start=1 latches num_vectors, clears vector_count and address; goes to DONE if num_vectors=0, else FETCH.
REQ-016 FETCH: rd_en=1 for exactly VECTOR_WIDTH consecutive cycles, rd_addr = vector_index*VECTOR_WIDTH + j, j=0..VECTOR_WIDTH-1.
REQ-017 Read data SHALL be captured into element j on the edge after its rd_en cycle; rd_data_a into vec_a, rd_data_b into vec_b.
REQ-018 vec_valid SHALL rise VECTOR_WIDTH+1 edges after the edge sampling start (5 by default); state then PRESENT.
REQ-019 PRESENT: vec_valid, vec_a, vec_b SHALL hold stable until vec_valid&&vec_ready; rd_en=0 throughout.
REQ-020 On transfer: vector_count increments; vec_valid drops next cycle; FETCH if vector_count+1 < num_vectors, else DONE.
REQ-021 DONE: reader_done=1 for exactly one cycle, then IDLE; reader_done never asserted elsewhere.
REQ-022 reader_busy=1 in FETCH and PRESENT, 0 in IDLE and DONE.
REQ-023 start outside IDLE SHALL be ignored; no restart, no re-latch of num_vectors.
REQ-024 rd_addr SHALL wrap modulo 2**ADDR_WIDTH when num_vectors*VECTOR_WIDTH exceeds depth.
REQ-025 vec_ready while vec_valid=0 SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, rd_en=0, rd_addr=0, vec_a=vec_b=0, vec_valid=0, reader_busy=0, reader_done=0, vector_count=0, including mid-FETCH or mid-PRESENT.
REQ-027 Read data returning in the cycle after reset release SHALL be discarded.

Configuration
REQ-028 With READER_STALL_CNT_EN defined: extra output stall_cycles (16 bits) counts PRESENT cycles with vec_ready=0, cleared on accepted start, saturates at 0xFFFF.
REQ-029 Without READER_STALL_CNT_EN: no stall_cycles port, no counter logic; all other behaviour identical.

Structure
REQ-030 FSM state enum and default widths SHALL live in the shared dot-product package used by the writer side.
REQ-031 A sub-module vector_packer (element shift/insert register for vec_a/vec_b) is natural; top holds FSM and counters.

Verification
REQ-032 Reset, mem1[0..3]=1,2,3,4, mem2[0..3]=5,6,7,8, start with num_vectors=1, vec_ready=1 -> vec_valid at edge 5, vec_a=0x04030201, vec_b=0x08070605, reader_done one cycle later, vector_count=1.
REQ-033 num_vectors=3, vec_ready low 10 cycles on vector 2 -> data stable, rd_en=0 while stalled, addresses 0..11 each read once, stall_cycles=10 when macro defined.
REQ-034 num_vectors=0 -> no rd_en, reader_done pulses, busy never high.
REQ-035 start pulsed during FETCH -> ignored; run completes with original num_vectors.
REQ-036 rst_n low during second FETCH of a 4-vector run -> all outputs reset at once; new start restarts from address 0.
REQ-037 ADDR_WIDTH=4, num_vectors=5 -> rd_addr wraps 15 -> 0 on vector 5; five transfers, one reader_done.
